or1200_enc_req_ctrl: RTL and testbench
======================================

OR1200_ENC_REQ_CTRL -- requirements
Module: or1200_enc_req_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, WAIT-state cycle limit (1..255); used only when OR1200_ENC_TIMEOUT_EN is defined.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  LSU encrypted-access request.
REQ-005 Port: req_load  in  1  1 = load, 0 = store.
REQ-006 Port: req_seedIn, req_seedAddr  in  5 each  seed register fields from decode.
REQ-007 Port: req_seedImm  in  11  seed immediate; only bits [9:0] are used, because bit 10 is regenerated.
REQ-008 Port: req_data  in  32  load data from cache, or store data from pipeline.
REQ-009 Port: flush  in  1  pipeline flush, aborts the request in flight.
REQ-010 Port: req_ready  out  1  high only in IDLE.
REQ-011 Port: stall  out  1  pipeline freeze while a request is in flight.
REQ-012 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-013 Port: rsp_data  out  32  transformed data, held until the next completion.
REQ-014 Port: rsp_err  out  1  timeout flag, valid together with rsp_valid.
REQ-015 Port: seedIn_o, seedAddr_o  out  5 each; seedImm_o  out  11.
- These drive the downstream encryption FSM top.
REQ-016 Port: dataIn_load_o, dataIn_store_o  out  32 each  data to the load and store engines.
REQ-017 Port: unstall_load, unstall_store  in  1 each  engine completion signals.
REQ-018 Port: dataOut_load, dataOut_store  in  32 each  engine results.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: when req_valid=1 and req_ready=1 on a clock edge:
- latch all req_* fields;
- go to ISSUE.
req_valid SHALL be ignored in every other state.
REQ-021 ISSUE SHALL last exactly one cycle, then go to WAIT.
REQ-022 In ISSUE and WAIT, seed outputs SHALL carry the latched fields, with seedImm_o[10] = latched req_load.
REQ-023 In ISSUE and WAIT, the latched req_data SHALL drive only the selected engine port; the other engine data port SHALL be 0.
REQ-024 In IDLE and DONE, all seed and engine data outputs SHALL be 0.
REQ-025 WAIT SHALL monitor only the selected engine's unstall (unstall_load when load, unstall_store when store).
- When it is 1: capture the matching dataOut_* into rsp_data and go to DONE.
- The other engine's unstall SHALL be ignored.
REQ-026 DONE SHALL last one cycle with rsp_valid=1, then go to IDLE.
REQ-027 stall SHALL be 1 in ISSUE and WAIT, and 0 in IDLE and DONE.
- Request-to-response latency is 2 + N cycles, where N is the WAIT cycles until unstall (minimum 3 cycles, unstall in the first WAIT cycle).
REQ-028 flush=1 in ISSUE or WAIT SHALL force IDLE on the next edge, with no rsp_valid and rsp_data unchanged.
REQ-029 flush in IDLE or DONE SHALL have no effect; DONE still pulses rsp_valid.
REQ-030 If flush and unstall occur in the same WAIT cycle, flush SHALL win.
REQ-031 A req_valid that is high in the same cycle as DONE SHALL be accepted only in the following IDLE cycle; there is no back-to-back bypass.

Reset
REQ-032 While rst=0, the block SHALL be forced asynchronously to IDLE.
- Every output SHALL read 0, except req_ready=1.
- rsp_data, the latched fields and the timeout counter SHALL clear to 0.
REQ-033 Reset asserted mid-request SHALL discard that request without producing rsp_valid.

Configuration
REQ-034 With OR1200_ENC_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment on each WAIT cycle.
- When the count reaches TIMEOUT without unstall: go to DONE with rsp_err=1 and rsp_data=0.
- When unstall arrives: rsp_err=0.
REQ-035 Without OR1200_ENC_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-036 Load, with unstall_load=1 in the first WAIT cycle:
- stimulus: req_load=1, req_seedIn=5'h03, req_seedImm=11'h005, req_data=32'hDEADBEEF, dataOut_load=32'h12345678;
- required: seedImm_o=11'h405, dataIn_load_o=32'hDEADBEEF, rsp_data=32'h12345678, rsp_valid on cycle 3, stall high for 2 cycles.
REQ-037 Store, with unstall_store after 5 WAIT cycles:
- stimulus: req_data=32'hA5A5A5A5, dataOut_store=32'h0F0F0F0F;
- required: seedImm_o[10]=0, dataIn_load_o=0, rsp_data=32'h0F0F0F0F, latency 7.
REQ-038 Load in WAIT with unstall_store=1 pulsed -> no completion; a later unstall_load=1 completes.
REQ-039 flush=1 in the same WAIT cycle as unstall_load=1 -> IDLE next cycle, no rsp_valid, rsp_data unchanged, req_ready=1.
REQ-040 rst=0 mid-WAIT -> all outputs 0 and req_ready=1 immediately, without waiting for a clock edge.
REQ-041 With OR1200_ENC_TIMEOUT_EN defined and TIMEOUT=4, no unstall -> rsp_valid=1, rsp_err=1, rsp_data=0 after 4 WAIT cycles.

Source files
------------

// File: rtl/or1200_enc_req_ctrl.sv
// or1200_enc_req_ctrl: sequences one encrypted LSU access through the load or store engine.
// Define OR1200_ENC_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with rsp_err.
module or1200_enc_req_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [4:0]  req_seedIn,
  input  logic [4:0]  req_seedAddr,
  input  logic [10:0] req_seedImm,
  input  logic [31:0] req_data,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [4:0]  seedIn_o,
  output logic [4:0]  seedAddr_o,
  output logic [10:0] seedImm_o,
  output logic [31:0] dataIn_load_o,
  output logic [31:0] dataIn_store_o,
  input  logic        unstall_load,
  input  logic        unstall_store,
  input  logic [31:0] dataOut_load,
  input  logic [31:0] dataOut_store
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nextState;
  logic latLoad;
  logic [4:0] latSeedIn, latSeedAddr;
  logic [9:0] latSeedImm;
  logic [31:0] latData, rspDataQ;
  logic busy, hit, timeUp, finish;
  // bit 10 of the immediate is rebuilt from the load/store direction
  logic unusedImmBit;
  assign unusedImmBit = req_seedImm[10];
  assign busy = state == ISSUE || state == WAIT;
  assign hit = latLoad ? unstall_load : unstall_store;
  assign finish = state == WAIT && !flush && (hit || timeUp);
`ifdef OR1200_ENC_TIMEOUT_EN
  logic [7:0] cnt;
  logic rspErrQ;
  assign timeUp = cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      rspErrQ <= 1'b0;
    end else begin
      cnt <= state == ISSUE ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
      if (finish) rspErrQ <= !hit;
    end
  assign rsp_err = rspErrQ && state == DONE;
`else
  assign timeUp = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = req_valid ? ISSUE : IDLE;
      ISSUE:   nextState = flush ? IDLE : WAIT;
      WAIT:    nextState = flush ? IDLE : (hit || timeUp) ? DONE : WAIT;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      latLoad <= 1'b0;
      latSeedIn <= '0;
      latSeedAddr <= '0;
      latSeedImm <= '0;
      latData <= '0;
      rspDataQ <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        latLoad <= req_load;
        latSeedIn <= req_seedIn;
        latSeedAddr <= req_seedAddr;
        latSeedImm <= req_seedImm[9:0];
        latData <= req_data;
      end
      if (finish) rspDataQ <= !hit ? 32'd0 : latLoad ? dataOut_load : dataOut_store;
    end
  assign req_ready = state == IDLE;
  assign stall = busy;
  assign rsp_valid = state == DONE;
  assign rsp_data = rspDataQ;
  assign seedIn_o = busy ? latSeedIn : '0;
  assign seedAddr_o = busy ? latSeedAddr : '0;
  assign seedImm_o = busy ? {latLoad, latSeedImm} : '0;
  assign dataIn_load_o = busy && latLoad ? latData : '0;
  assign dataIn_store_o = busy && !latLoad ? latData : '0;
endmodule

// File: tb/tb_or1200_enc_req_ctrl.sv
// tb_or1200_enc_req_ctrl: directed and randomized requests checked against a cycle-level model.
module tb_or1200_enc_req_ctrl;
`ifdef OR1200_ENC_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_load = 1'b0, flush = 1'b0;
  logic unstall_load = 1'b0, unstall_store = 1'b0;
  logic [4:0] req_seedIn = '0, req_seedAddr = '0;
  logic [10:0] req_seedImm = '0;
  logic [31:0] req_data = '0, dataOut_load = '0, dataOut_store = '0;
  logic req_ready, stall, rsp_valid, rsp_err;
  logic [31:0] rsp_data, dataIn_load_o, dataIn_store_o;
  logic [4:0] seedIn_o, seedAddr_o;
  logic [10:0] seedImm_o;
  int errors = 0, checks = 0;
  logic [31:0] expRsp = '0;

  always #5 clk = ~clk;

  or1200_enc_req_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load),
    .req_seedIn(req_seedIn), .req_seedAddr(req_seedAddr), .req_seedImm(req_seedImm),
    .req_data(req_data), .flush(flush), .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .seedIn_o(seedIn_o), .seedAddr_o(seedAddr_o), .seedImm_o(seedImm_o),
    .dataIn_load_o(dataIn_load_o), .dataIn_store_o(dataIn_store_o),
    .unstall_load(unstall_load), .unstall_store(unstall_store),
    .dataOut_load(dataOut_load), .dataOut_store(dataOut_store)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkQuiet(input string tag, input bit ready, input bit valid);
    chk({tag, ":ready"}, 32'(req_ready), 32'(ready));
    chk({tag, ":stall"}, 32'(stall), 32'd0);
    chk({tag, ":valid"}, 32'(rsp_valid), 32'(valid));
    chk({tag, ":seeds"}, 32'({seedIn_o, seedAddr_o, seedImm_o}), 32'd0);
    chk({tag, ":dLoad"}, dataIn_load_o, 32'd0);
    chk({tag, ":dStore"}, dataIn_store_o, 32'd0);
  endtask

  task automatic chkBusy(input string tag, input bit ld, input logic [4:0] sIn, input logic [4:0] sAddr,
                         input logic [10:0] sImm, input logic [31:0] d);
    chk({tag, ":ready"}, 32'(req_ready), 32'd0);
    chk({tag, ":stall"}, 32'(stall), 32'd1);
    chk({tag, ":valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":seedIn"}, 32'(seedIn_o), 32'(sIn));
    chk({tag, ":seedAddr"}, 32'(seedAddr_o), 32'(sAddr));
    chk({tag, ":seedImm"}, 32'(seedImm_o), 32'({ld, sImm[9:0]}));
    chk({tag, ":dLoad"}, dataIn_load_o, ld ? d : 32'd0);
    chk({tag, ":dStore"}, dataIn_store_o, ld ? 32'd0 : d);
  endtask

  // Starts and ends on a falling edge with the block idle; flushAt 0 = ISSUE, k = k-th WAIT cycle, -1 = never.
  task automatic runReq(input string tag, input bit ld, input logic [4:0] sIn, input logic [4:0] sAddr,
                        input logic [10:0] sImm, input logic [31:0] d, input logic [31:0] res,
                        input int waitN, input int flushAt, input bit noise);
    chk({tag, ":idleReady"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_load = ld; req_seedIn = sIn; req_seedAddr = sAddr; req_seedImm = sImm; req_data = d;
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_load = ~ld; req_seedIn = ~sIn; req_seedAddr = ~sAddr; req_seedImm = ~sImm; req_data = ~d;
    chkBusy({tag, "/issue"}, ld, sIn, sAddr, sImm, d);
    flush = flushAt == 0;
    @(negedge clk);
    if (flushAt == 0) begin
      flush = 1'b0; req_valid = 1'b0;
      chkQuiet({tag, "/flushIssue"}, 1'b1, 1'b0);
      chk({tag, "/flushIssue:rsp"}, rsp_data, expRsp);
      return;
    end
    for (int w = 1; w <= waitN; w++) begin
      chkBusy($sformatf("%s/wait%0d", tag, w), ld, sIn, sAddr, sImm, d);
      dataOut_load = (ld && w == waitN) ? res : $urandom;
      dataOut_store = (!ld && w == waitN) ? res : $urandom;
      unstall_load = ld ? (w == waitN) : noise;
      unstall_store = ld ? noise : (w == waitN);
      flush = w == flushAt;
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      unstall_load = 1'b0; unstall_store = 1'b0; req_valid = 1'b0;
      if (w == flushAt) begin
        flush = 1'b0;
        chkQuiet({tag, "/flushWait"}, 1'b1, 1'b0);
        chk({tag, "/flushWait:rsp"}, rsp_data, expRsp);
        return;
      end
    end
    expRsp = res;
    chkQuiet({tag, "/done"}, 1'b0, 1'b1);
    chk({tag, "/done:rsp"}, rsp_data, expRsp);
    chk({tag, "/done:err"}, 32'(rsp_err), 32'd0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chkQuiet({tag, "/after"}, 1'b1, 1'b0);
    chk({tag, "/after:rsp"}, rsp_data, expRsp);
  endtask

  initial begin
    #1;
    chkQuiet("reset", 1'b1, 1'b0);
    chk("reset:rsp", rsp_data, 32'd0);
    chk("reset:err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runReq("load1", 1'b1, 5'h03, 5'h00, 11'h005, 32'hDEADBEEF, 32'h12345678, 1, -1, 1'b0);
`ifndef OR1200_ENC_TIMEOUT_EN
    runReq("store5", 1'b0, 5'h11, 5'h0A, 11'h7FF, 32'hA5A5A5A5, 32'h0F0F0F0F, 5, -1, 1'b0);
    runReq("longWait", 1'b0, 5'h1F, 5'h01, 11'h2AA, 32'h01234567, 32'h89ABCDEF, 70, -1, 1'b1);
`endif
    runReq("wrongUnstall", 1'b1, 5'h07, 5'h15, 11'h155, 32'hCAFEF00D, 32'h55AA55AA, 4, -1, 1'b1);
    runReq("flushUnstall", 1'b1, 5'h02, 5'h04, 11'h3C3, 32'h11111111, 32'h22222222, 2, 2, 1'b0);
    runReq("flushIssue", 1'b0, 5'h09, 5'h12, 11'h001, 32'h33333333, 32'h44444444, 3, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      int n, f;
      n = $urandom_range(1, 4);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      runReq($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 11'($urandom),
             $urandom, $urandom, n, f, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b1; req_load = 1'b1; req_seedIn = 5'h0C; req_seedImm = 11'h0FF; req_data = 32'h77777777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midWait:stall", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chkQuiet("asyncRst", 1'b1, 1'b0);
    chk("asyncRst:rsp", rsp_data, 32'd0);
    chk("asyncRst:err", 32'(rsp_err), 32'd0);
    expRsp = '0;
    @(negedge clk);
    rst = 1'b1;
    unstall_load = 1'b1;
    dataOut_load = 32'hBADBAD00;
    @(negedge clk);
    unstall_load = 1'b0;
    chkQuiet("postRst", 1'b1, 1'b0);
    chk("postRst:rsp", rsp_data, 32'd0);
`ifdef OR1200_ENC_TIMEOUT_EN
    req_valid = 1'b1; req_load = 1'b1; req_seedIn = 5'h01; req_seedAddr = 5'h02; req_seedImm = 11'h003;
    req_data = 32'h99999999;
    @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w <= TO; w++) begin
      chkBusy($sformatf("timeout/c%0d", w), 1'b1, 5'h01, 5'h02, 11'h003, 32'h99999999);
      @(negedge clk);
    end
    chk("timeout:valid", 32'(rsp_valid), 32'd1);
    chk("timeout:err", 32'(rsp_err), 32'd1);
    chk("timeout:rsp", rsp_data, 32'd0);
    @(negedge clk);
    chkQuiet("timeout/after", 1'b1, 1'b0);
    chk("timeout/after:err", 32'(rsp_err), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
